// File: rtl/motoro3_step_sequencer.sv
// Commutation step sequencer: PWM period counter, per-step period counter and
// electrical step index with a graceful stop at the end of the current step.
module motoro3_step_sequencer #(
   parameter int STEP_NUM = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        dirRev,
   input  logic [7:0]  pwmLen,
   input  logic [15:0] slLen,
   output logic [3:0]  lcStep,
   output logic [7:0]  pwmCnt,
   output logic        pwmTick,
   output logic [15:0] stepCnt,
   output logic        stepTick,
   output logic        cycleTick,
   output logic        running
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STOPPING
   } state_t;

   localparam logic [4:0] STEP_NUM_W = 5'(STEP_NUM);
   localparam logic [3:0] STEP_LAST  = 4'(STEP_NUM - 1);

   state_t      state_q, state_d;
   logic [3:0]  lc_step_q, lc_step_d;
   logic [7:0]  pwm_cnt_q, pwm_cnt_d;
   logic [15:0] step_cnt_q, step_cnt_d;
   logic [7:0]  pwm_len_r_q, pwm_len_r_d;

   logic        active;
   logic [7:0]  pwm_len_eff;
   logic [15:0] sl_len_eff;
   logic        pwm_tick;
   logic        step_tick;
   logic        wrap;
   logic [3:0]  lc_step_adv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lc_step_q   <= 4'd0;
         pwm_cnt_q   <= 8'd0;
         step_cnt_q  <= 16'd0;
         pwm_len_r_q <= 8'd1;
      end else begin
         state_q     <= state_d;
         lc_step_q   <= lc_step_d;
         pwm_cnt_q   <= pwm_cnt_d;
         step_cnt_q  <= step_cnt_d;
         pwm_len_r_q <= pwm_len_r_d;
      end
   end

   always_comb begin
      active      = (state_q != ST_IDLE);
      pwm_len_eff = (pwmLen == 8'd0) ? 8'd1 : pwmLen;
      sl_len_eff  = (slLen == 16'd0) ? 16'd1 : slLen;
      pwm_tick    = active && (pwm_cnt_q == pwm_len_r_q - 8'd1);
      // >= rather than == so a shrinking slLen ends the step at the next period end
      step_tick   = pwm_tick && (step_cnt_q >= sl_len_eff - 16'd1);

      wrap        = 1'b0;
      lc_step_adv = 4'd0;
      if ({1'b0, lc_step_q} >= STEP_NUM_W) begin
         lc_step_adv = 4'd0;
      end else if (!dirRev) begin
         wrap        = (lc_step_q == STEP_LAST);
         lc_step_adv = wrap ? 4'd0 : lc_step_q + 4'd1;
      end else begin
         wrap        = (lc_step_q == 4'd0);
         lc_step_adv = wrap ? STEP_LAST : lc_step_q - 4'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      lc_step_d   = lc_step_q;
      pwm_cnt_d   = pwm_cnt_q;
      step_cnt_d  = step_cnt_q;
      pwm_len_r_d = pwm_len_r_q;

      case (state_q)
         ST_IDLE: begin
            pwm_cnt_d  = 8'd0;
            step_cnt_d = 16'd0;
            if (enable) begin
               state_d     = ST_RUN;
               pwm_len_r_d = pwm_len_eff;
            end
         end
         ST_RUN, ST_STOPPING: begin
            pwm_cnt_d = pwm_tick ? 8'd0 : pwm_cnt_q + 8'd1;
            if (pwm_tick) begin
               pwm_len_r_d = pwm_len_eff;
            end
            if (step_tick) begin
               step_cnt_d = 16'd0;
               lc_step_d  = lc_step_adv;
            end else if (pwm_tick) begin
               step_cnt_d = step_cnt_q + 16'd1;
            end
            // A stop request only takes effect once the current step has finished
            if (!enable) begin
               state_d = step_tick ? ST_IDLE : ST_STOPPING;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign lcStep    = lc_step_q;
   assign pwmCnt    = pwm_cnt_q;
   assign stepCnt   = step_cnt_q;
   assign pwmTick   = pwm_tick;
   assign stepTick  = step_tick;
   assign cycleTick = step_tick && wrap;
   assign running   = active;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Randomized and directed bench for motoro3_step_sequencer against a
// cycle-level behavioural model of the step sequence.
module tb_motoro3_step_sequencer;

   localparam int N = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        dir_rev;
   logic [7:0]  pwm_len;
   logic [15:0] sl_len;
   logic [3:0]  lc_step;
   logic [7:0]  pwm_cnt;
   logic        pwm_tick;
   logic [15:0] step_cnt;
   logic        step_tick;
   logic        cycle_tick;
   logic        running;

   logic [15:0] sl_table [16];

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state
   int m_active, m_lc, m_pos, m_periods, m_plen;
   int cnt_pt, cnt_st, cnt_ct;
   int tick_pos[$];

   always #5 clk = ~clk;

   assign sl_len = sl_table[lc_step];

   motoro3_step_sequencer #(.STEP_NUM(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .dirRev    (dir_rev),
      .pwmLen    (pwm_len),
      .slLen     (sl_len),
      .lcStep    (lc_step),
      .pwmCnt    (pwm_cnt),
      .pwmTick   (pwm_tick),
      .stepCnt   (step_cnt),
      .stepTick  (step_tick),
      .cycleTick (cycle_tick),
      .running   (running)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active  = 0;
      m_lc      = 0;
      m_pos     = 0;
      m_periods = 0;
      m_plen    = 1;
   endtask

   // One clock: compare at negedge, advance the model at posedge, return at posedge+1.
   task automatic cycle();
      int sl_eff;
      bit pt, st, ct;
      @(negedge clk);
      sl_eff = (sl_table[m_lc] == 16'd0) ? 1 : int'(sl_table[m_lc]);
      pt = (m_active != 0) && (m_pos == m_plen - 1);
      st = pt && (m_periods + 1 >= sl_eff);
      ct = st && ((!dir_rev && m_lc == N - 1) || (dir_rev && m_lc == 0));
      check_val("lcStep",    lc_step,    m_lc);
      check_val("pwmCnt",    pwm_cnt,    m_pos);
      check_val("stepCnt",   step_cnt,   m_periods);
      check_val("pwmTick",   pwm_tick,   pt);
      check_val("stepTick",  step_tick,  st);
      check_val("cycleTick", cycle_tick, ct);
      check_val("running",   running,    m_active);
      cnt_pt += int'(pwm_tick);
      cnt_st += int'(step_tick);
      cnt_ct += int'(cycle_tick);
      if (pwm_tick) tick_pos.push_back(int'(pwm_cnt));
      @(posedge clk);
      if (m_active == 0) begin
         if (enable) begin
            m_active = 1;
            m_plen   = (pwm_len == 8'd0) ? 1 : int'(pwm_len);
         end
      end else begin
         if (pt) m_plen = (pwm_len == 8'd0) ? 1 : int'(pwm_len);
         m_pos = pt ? 0 : m_pos + 1;
         if (st) begin
            m_periods = 0;
            m_lc      = dir_rev ? (m_lc + N - 1) % N : (m_lc + 1) % N;
            if (!enable) m_active = 0;
         end else if (pt) begin
            m_periods++;
         end
      end
      #1;
   endtask

   task automatic clear_counts();
      cnt_pt = 0;
      cnt_st = 0;
      cnt_ct = 0;
      tick_pos.delete();
   endtask

   task automatic fill_table(input int v);
      for (int i = 0; i < 16; i++) sl_table[i] = 16'(v);
   endtask

   initial begin
      int saved_lc;
      bit reached;

      rst     = 1'b1;
      enable  = 1'b0;
      dir_rev = 1'b0;
      pwm_len = 8'd4;
      fill_table(3);
      model_reset();
      clear_counts();
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_lcStep",   lc_step,   0);
      check_val("rst_pwmCnt",   pwm_cnt,   0);
      check_val("rst_stepCnt",  step_cnt,  0);
      check_val("rst_ticks",    {pwm_tick, step_tick, cycle_tick}, 0);
      check_val("rst_running",  running,   0);
      rst = 1'b0;
      $display("[TB] reset state checked");

      // pwmLen=4, slLen=3: 12-clk steps, full forward electrical cycle
      enable = 1'b1;
      cycle();
      clear_counts();
      repeat (144) cycle();
      check_val("fwd_pwm_ticks",   cnt_pt, 36);
      check_val("fwd_step_ticks",  cnt_st, 12);
      check_val("fwd_cycle_ticks", cnt_ct, 1);
      check_val("fwd_lc_end",      lc_step, 0);
      $display("[TB] forward cycle: %0d steps, %0d wraps", cnt_st, cnt_ct);

      // reverse from lcStep=0, with dirRev toggled away mid-step only
      clear_counts();
      for (int i = 0; i < 60; i++) begin
         dir_rev = (m_periods == 1) ? 1'b0 : 1'b1;
         cycle();
      end
      dir_rev = 1'b1;
      check_val("rev_cycle_ticks", cnt_ct, 1);
      check_val("rev_lc_end",      lc_step, 7);
      $display("[TB] reverse run ended at lcStep=%0d", lc_step);

      // stop request at stepCnt=1 completes the step then idles
      dir_rev = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         if (m_periods == 1) reached = 1'b1;
         else cycle();
      end
      check_val("stop_wait", reached, 1);
      saved_lc = int'(lc_step);
      enable   = 1'b0;
      reached  = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         cycle();
         if (m_active == 0) reached = 1'b1;
      end
      check_val("stop_idle_wait", reached, 1);
      check_val("stop_lc_adv",    lc_step, (saved_lc + 1) % N);
      repeat (4) cycle();
      $display("[TB] stop completed at lcStep=%0d", lc_step);

      // stop request withdrawn before the step ends
      enable  = 1'b1;
      reached = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         cycle();
         if (m_periods == 1) reached = 1'b1;
      end
      check_val("reen_wait", reached, 1);
      enable = 1'b0;
      repeat (3) cycle();
      enable = 1'b1;
      clear_counts();
      repeat (24) cycle();
      check_val("reen_steps", cnt_st, 2);
      $display("[TB] re-enable before step end kept running");

      // pwmLen=0 and slLen=0 behave as 1: ticks every clock
      pwm_len = 8'd0;
      fill_table(0);
      repeat (6) cycle();
      clear_counts();
      repeat (16) cycle();
      check_val("min_pwm_ticks",  cnt_pt, 16);
      check_val("min_step_ticks", cnt_st, 16);
      $display("[TB] minimum lengths: %0d step ticks in 16 clk", cnt_st);

      // pwmLen 6 -> 2 mid-period
      pwm_len = 8'd6;
      fill_table(4);
      reached = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         cycle();
         if (m_plen == 6 && m_pos == 0) reached = 1'b1;
      end
      check_val("plen6_wait", reached, 1);
      clear_counts();
      repeat (2) cycle();
      pwm_len = 8'd2;
      repeat (6) cycle();
      check_val("plen_ticks", tick_pos.size(), 2);
      if (tick_pos.size() >= 2) begin
         check_val("plen_first_end",  tick_pos[0], 5);
         check_val("plen_second_end", tick_pos[1], 1);
      end
      $display("[TB] pwmLen change applied at period boundary");

      // asynchronous reset in the middle of step 5
      pwm_len = 8'd4;
      fill_table(3);
      reached = 1'b0;
      for (int i = 0; i < 400 && !reached; i++) begin
         if (m_lc == 5 && m_periods == 1 && m_pos == 2) reached = 1'b1;
         else cycle();
      end
      check_val("arst_wait", reached, 1);
      #2 rst = 1'b1;
      #1;
      check_val("arst_lcStep",  lc_step,  0);
      check_val("arst_pwmCnt",  pwm_cnt,  0);
      check_val("arst_stepCnt", step_cnt, 0);
      check_val("arst_ticks",   {pwm_tick, step_tick, cycle_tick}, 0);
      check_val("arst_running", running,  0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      clear_counts();
      repeat (30) cycle();
      check_val("arst_restart_lc", lc_step, 2);
      $display("[TB] async reset restart reached lcStep=%0d", lc_step);

      // randomized operation
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) enable  = ~enable;
         if ($urandom_range(0, 7) == 0)  dir_rev = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0)  pwm_len = 8'($urandom_range(0, 5));
         if ($urandom_range(0, 5) == 0)  sl_table[$urandom_range(0, N - 1)] = 16'($urandom_range(0, 4));
         if ($urandom_range(0, 19) == 0) sl_table[m_lc] = 16'($urandom_range(0, 4));
         cycle();
      end
      $display("[TB] random phase ended at lcStep=%0d", lc_step);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/motoro3_step_sequencer.md
MOTORO3_STEP_SEQUENCER -- requirements
Module: motoro3_step_sequencer

Parameters
REQ-001 STEP_NUM, default 12, number of commutation steps per electrical cycle; lcStep counts 0..STEP_NUM-1; legal range 2..16.

Interface
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 enable  input  1  level; 1 = run the step sequence, 0 = request stop.
REQ-005 dirRev  input  1  level; 0 = lcStep increments, 1 = lcStep decrements; sampled only at step boundaries.
REQ-006 pwmLen  input  8  PWM period length in clk cycles; sampled only at PWM period start.
REQ-007 slLen  input  16  PWM periods per step, from the sine-length calculator (combinational function of lcStep).
REQ-008 lcStep  output  4  current commutation step; drives the line-parameter calculator.
REQ-009 pwmCnt  output  8  position inside the current PWM period.
REQ-010 pwmTick  output  1  one-cycle pulse on the last clk of each PWM period.
REQ-011 stepCnt  output  16  PWM periods completed in the current step.
REQ-012 stepTick  output  1  one-cycle pulse on the last clk of each step.
REQ-013 cycleTick  output  1  one-cycle pulse with stepTick when lcStep wraps (STEP_NUM-1->0 forward, 0->STEP_NUM-1 reverse).
REQ-014 running  output  1  1 while FSM is in RUN or STOPPING.

Function
REQ-015 FSM states: IDLE, RUN, STOPPING; encoding is free.
REQ-016 IDLE->RUN when enable=1; the first RUN cycle has pwmCnt=0, stepCnt=0, lcStep unchanged.
REQ-017 RUN->STOPPING when enable=0; the current step runs to completion.
REQ-018 STOPPING->RUN when enable returns to 1 before stepTick; no counter disturbance.
REQ-019 STOPPING->IDLE on the cycle after stepTick; lcStep takes the advanced value and pwmCnt/stepCnt clear to 0.
REQ-020 IDLE: pwmCnt, stepCnt and all ticks are held at 0; lcStep holds its value.
REQ-021 Internal pwmLenR latches pwmLen on entry to RUN and on every pwmTick; pwmLen=0 is treated as 1.
REQ-022 pwmCnt increments each RUN/STOPPING cycle; pwmTick=1 when pwmCnt==pwmLenR-1; pwmCnt then wraps to 0 next cycle.
REQ-023 stepCnt increments on each pwmTick; slLen=0 is treated as 1.
REQ-024 stepTick = pwmTick AND stepCnt>=slLen-1; the >= comparison makes an slLen decrease mid-step end the step at the next pwmTick.
REQ-025 On stepTick, in the next cycle stepCnt=0 and lcStep advances by +/-1 per dirRev, modulo STEP_NUM.
REQ-026 dirRev changes between step boundaries have no effect until the next stepTick.
REQ-027 Latency: lcStep changes exactly 1 clk after stepTick; slLen is combinationally valid for the new step in that same cycle.
REQ-028 Counter widths: pwmCnt 8-bit and stepCnt 16-bit; neither may overflow given REQ-022/024.
REQ-029 An out-of-range lcStep (>=STEP_NUM, unreachable) advances to 0.

Reset
REQ-030 While rst=1 (asynchronous assertion): state=IDLE, lcStep=0, pwmCnt=0, stepCnt=0, pwmTick=stepTick=cycleTick=0, running=0, pwmLenR=1.
REQ-031 Reset mid-step discards all progress; after release, operation restarts per REQ-016.
REQ-032 Reset deassertion is assumed synchronized upstream; the block adds no synchronizer.

Verification
REQ-033 pwmLen=4, slLen=3, enable=1 from reset -> pwmTick every 4 clk, stepTick every 12 clk, lcStep 0,1,2,...,11,0 with cycleTick on the 11->0 transition.
REQ-034 dirRev=1 and lcStep=0 at a step boundary -> lcStep=11 next cycle with cycleTick=1; dirRev toggled mid-step -> no effect before stepTick.
REQ-035 enable dropped at stepCnt=1 of slLen=3 -> running stays 1 until stepTick, then IDLE with lcStep advanced by 1; a re-enable before stepTick -> no interruption.
REQ-036 pwmLen=0 and slLen=0 -> pwmTick and stepTick every clk, and lcStep advances every clk.
REQ-037 pwmLen changed 6->2 mid-period -> the current period finishes at 6 clk and the next period is 2 clk.
REQ-038 rst pulsed mid-step at lcStep=5 -> all outputs 0 immediately (asynchronous), and a restart from lcStep=0.
